player_motion_ctrl: RTL
=======================

Name: player_motion_ctrl

Overview:
- Per-frame movement sequencer for the player sprite.
- Decodes the USB keycode into a walk/jump/fall/attack state machine and drives signed X/Y motion commands to the player position datapath.
- Takes position feedback from that datapath for floor and wall decisions.
- Sits between the keyboard keycode register and the player position register; one decision per frame tick.

Parameters:
- WALK_STEP, 2, horizontal pixels per tick while walking
- JUMP_V, 12, initial upward speed (pixels/tick) on jump
- GRAVITY, 1, Y_Motion increment per airborne tick
- MAX_FALL, 8, downward speed saturation
- FLOOR_Y, 400, Y coordinate of the floor surface
- X_MIN, 0, left wall; X_MAX, 639, right wall
- ATTACK_TICKS, 6, ticks the attack window stays open
- COOLDOWN_TICKS, 10, ticks after attack end before a new attack is accepted

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-Clk pulse per frame; all state advances only when high
- keycode  in  8  current key (0x04 A, 0x07 D, 0x1A W = jump, 0x0D J = attack, other = none)
- X_Pos, Y_Pos  in  10  current player centre from the position datapath
- Size  in  10  player half-size
- X_Motion, Y_Motion  out  10  signed two's-complement step per tick
- state  out  3  player_pkg::pstate_t
- facing_right  out  1  1 = facing right
- attack_active  out  1  high during the attack window

Behaviour:
- Reset_n low (async):
  - X_Motion=0, Y_Motion=0, state=IDLE, facing_right=1, attack_active=0.
  - Attack and cooldown counters =0; prev_key=0.
- frame_tick low: all registers hold.
- Signals evaluated on each tick:
  - on_ground = (Y_Pos + Size >= FLOOR_Y).
  - jump_edge = (keycode==0x1A && prev_key!=0x1A); atk_edge likewise for 0x0D.
  - prev_key <= keycode every tick.
  - Only one keycode exists per tick, so jump and attack cannot coincide.
- Horizontal, all states except ATTACK:
  - A: X_Motion=-WALK_STEP, facing_right=0.
  - D: X_Motion=+WALK_STEP, facing_right=1.
  - Otherwise X_Motion=0.
  - Wall clamp: X_Motion forced 0 if moving left and X_Pos-Size<=X_MIN+WALK_STEP, or moving right and X_Pos+Size>=X_MAX-WALK_STEP.
- States:
  - IDLE/WALK:
    - !on_ground -> FALL.
    - Else jump_edge -> JUMP with Y_Motion=-JUMP_V.
    - Else atk_edge and cooldown==0 -> ATTACK.
    - Else WALK if A/D held, IDLE otherwise; Y_Motion=0.
  - JUMP:
    - Y_Motion += GRAVITY each tick.
    - When the new value is >=0 (signed) -> FALL.
  - FALL:
    - Y_Motion = min(Y_Motion+GRAVITY, MAX_FALL).
    - Landing: on_ground and Y_Motion>=0 -> Y_Motion=0, then WALK if A/D held, else IDLE.
  - ATTACK:
    - X_Motion=0, Y_Motion=0, attack_active=1.
    - Counter loads ATTACK_TICKS-1 on entry and decrements per tick.
    - At 0: -> IDLE and cooldown loads COOLDOWN_TICKS.
- Cooldown decrements per tick to 0 in every state. Attack edges in air or during cooldown are dropped, not queued.
- Signed arithmetic: compute Y_Motion in 11-bit signed, then truncate. MAX_FALL saturation prevents overflow.
- Reset mid-jump or mid-attack: immediate return to reset values. The first tick after reset re-evaluates on_ground.

Optional Feature:
- Macro: PLAYER_DOUBLE_JUMP_EN.
- Defined:
  - One air-jump credit, set on entering JUMP from ground.
  - jump_edge in JUMP/FALL with credit=1 -> Y_Motion=-JUMP_V, state=JUMP, credit=0.
  - Credit cleared on landing and on reset.
- Undefined: jump_edge while airborne is ignored; no credit register exists.

Decomposition:
- Package player_pkg:
  - pstate_t enum (IDLE=0, WALK=1, JUMP=2, FALL=3, ATTACK=4).
  - Keycode constants KEY_A, KEY_D, KEY_W, KEY_J.
  - Shared floor/wall defaults for the position and sprite blocks.
- One sub-module: player_attack_timer.
  - Owns the attack and cooldown counters.
  - Inputs: start and frame_tick.
  - Outputs: attack_active, attack_done, ready.

Test Plan:
- Reset with Y_Pos=300, Size=4 and ticks -> FALL; Y_Motion 1,2,...,8 then holds at 8; Y_Pos=396 with Y_Motion>=0 -> IDLE, Y_Motion=0.
- On ground, keycode 0x1A held 20 ticks -> single jump: Y_Motion -12, then -11…-1 in JUMP, FALL at tick 12 (Y_Motion=0); no re-jump while held.
- keycode 0x07 with X_Pos=633, Size=4 -> X_Motion=0, facing_right=1; keycode 0x04 at X_Pos=320 -> X_Motion=-2 (0x3FE), facing_right=0.
- On ground, J pressed -> attack_active high exactly 6 ticks, X/Y_Motion=0; J re-pressed 5 ticks after end -> ignored; J pressed 10 ticks after end -> accepted.
- Reset_n asserted mid-jump between Clk edges -> outputs return to reset values immediately, without waiting for a Clk edge.
- With PLAYER_DOUBLE_JUMP_EN: jump, release, press W at Y_Motion=-3 -> Y_Motion=-12; third press ignored. Without the macro: second press ignored.

Source files
------------

// File: rtl/player_pkg.sv
// Shared types and constants for the player movement blocks: FSM state encoding,
// keyboard keycodes and default floor/wall geometry.
package player_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWalk   = 3'd1,
    StJump   = 3'd2,
    StFall   = 3'd3,
    StAttack = 3'd4
  } pstate_t;

  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_J = 8'h0D;

  localparam int DefFloorY = 400;
  localparam int DefXMin   = 0;
  localparam int DefXMax   = 639;

  function automatic logic is_walk_key(input logic [7:0] key);
    return (key == KEY_A) || (key == KEY_D);
  endfunction

endpackage

// File: rtl/player_attack_timer.sv
// Attack window and post-attack cooldown counters; advances only on frame ticks.
module player_attack_timer #(
  parameter int ATTACK_TICKS   = 6,
  parameter int COOLDOWN_TICKS = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic start_i,
  output logic attack_active_o,
  output logic attack_done_o,
  output logic ready_o
);

  localparam int AtkW  = (ATTACK_TICKS > 1) ? $clog2(ATTACK_TICKS) : 1;
  localparam int CoolW = $clog2(COOLDOWN_TICKS + 1);

  logic [AtkW-1:0]  atk_cnt_q, atk_cnt_d;
  logic [CoolW-1:0] cool_cnt_q, cool_cnt_d;
  logic             active_q, active_d;

  always_comb begin
    atk_cnt_d  = atk_cnt_q;
    cool_cnt_d = cool_cnt_q;
    active_d   = active_q;
    if (tick_i) begin
      if (cool_cnt_q != '0) cool_cnt_d = cool_cnt_q - 1'b1;
      if (start_i) begin
        active_d  = 1'b1;
        atk_cnt_d = AtkW'(ATTACK_TICKS - 1);
      end else if (active_q) begin
        if (atk_cnt_q == '0) begin
          active_d   = 1'b0;
          cool_cnt_d = CoolW'(COOLDOWN_TICKS);
        end else begin
          atk_cnt_d = atk_cnt_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      atk_cnt_q  <= '0;
      cool_cnt_q <= '0;
      active_q   <= 1'b0;
    end else begin
      atk_cnt_q  <= atk_cnt_d;
      cool_cnt_q <= cool_cnt_d;
      active_q   <= active_d;
    end
  end

  assign attack_active_o = active_q;
  assign attack_done_o   = active_q && (atk_cnt_q == '0);
  assign ready_o         = !active_q && (cool_cnt_q == '0);

endmodule

// File: rtl/player_motion_ctrl.sv
// Per-frame player movement FSM (idle/walk/jump/fall/attack) driving signed X/Y steps.
// Define PLAYER_DOUBLE_JUMP_EN to allow one extra jump while airborne.
module player_motion_ctrl
  import player_pkg::*;
#(
  parameter int WALK_STEP      = 2,
  parameter int JUMP_V         = 12,
  parameter int GRAVITY        = 1,
  parameter int MAX_FALL       = 8,
  parameter int FLOOR_Y        = DefFloorY,
  parameter int X_MIN          = DefXMin,
  parameter int X_MAX          = DefXMax,
  parameter int ATTACK_TICKS   = 6,
  parameter int COOLDOWN_TICKS = 10
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  input  logic [9:0] X_Pos,
  input  logic [9:0] Y_Pos,
  input  logic [9:0] Size,
  output logic [9:0] X_Motion,
  output logic [9:0] Y_Motion,
  output pstate_t    state,
  output logic       facing_right,
  output logic       attack_active
);

  localparam logic [9:0]         WalkPos   = 10'(WALK_STEP);
  localparam logic [9:0]         WalkNeg   = 10'(-WALK_STEP);
  localparam logic [9:0]         JumpNeg   = 10'(-JUMP_V);
  localparam logic signed [10:0] Grav11    = 11'(GRAVITY);
  localparam logic signed [10:0] MaxFall11 = 11'(MAX_FALL);
  localparam logic [10:0]        FloorY11  = 11'(FLOOR_Y);
  localparam logic signed [11:0] XLoLim    = 12'(X_MIN + WALK_STEP);
  localparam logic signed [11:0] XHiLim    = 12'(X_MAX - WALK_STEP);

  pstate_t    state_q, state_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       facing_q, facing_d;
  logic [7:0] prev_key_q, prev_key_d;
`ifdef PLAYER_DOUBLE_JUMP_EN
  logic       credit_q, credit_d;
`endif

  logic              on_ground, jump_edge, atk_edge;
  logic              left_block, right_block;
  logic signed [11:0] x_lo, x_hi;
  logic signed [10:0] y_inc;
  logic              atk_start, atk_done, atk_ready, atk_active;

  // 12-bit signed edges so X_Pos - Size cannot wrap near the left wall.
  assign x_lo        = $signed({2'b00, X_Pos}) - $signed({2'b00, Size});
  assign x_hi        = $signed({2'b00, X_Pos}) + $signed({2'b00, Size});
  assign left_block  = (x_lo <= XLoLim);
  assign right_block = (x_hi >= XHiLim);
  assign on_ground   = ({1'b0, Y_Pos} + {1'b0, Size}) >= FloorY11;
  assign jump_edge   = (keycode == KEY_W) && (prev_key_q != KEY_W);
  assign atk_edge    = (keycode == KEY_J) && (prev_key_q != KEY_J);
  assign y_inc       = $signed({y_q[9], y_q}) + Grav11;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    facing_d   = facing_q;
    prev_key_d = prev_key_q;
    atk_start  = 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
    credit_d   = credit_q;
`endif
    if (frame_tick) begin
      prev_key_d = keycode;
      if (state_q != StAttack) begin
        x_d = '0;
        if (keycode == KEY_A) begin
          facing_d = 1'b0;
          if (!left_block) x_d = WalkNeg;
        end else if (keycode == KEY_D) begin
          facing_d = 1'b1;
          if (!right_block) x_d = WalkPos;
        end
      end
      case (state_q)
        StIdle, StWalk: begin
          y_d = '0;
          if (!on_ground) begin
            state_d = StFall;
          end else if (jump_edge) begin
            state_d = StJump;
            y_d     = JumpNeg;
`ifdef PLAYER_DOUBLE_JUMP_EN
            credit_d = 1'b1;
`endif
          end else if (atk_edge && atk_ready) begin
            state_d   = StAttack;
            atk_start = 1'b1;
            x_d       = '0;
          end else begin
            state_d = is_walk_key(keycode) ? StWalk : StIdle;
          end
        end
        StJump: begin
`ifdef PLAYER_DOUBLE_JUMP_EN
          if (jump_edge && credit_q) begin
            y_d      = JumpNeg;
            credit_d = 1'b0;
          end else
`endif
          begin
            y_d = y_inc[9:0];
            if (!y_inc[10]) state_d = StFall;
          end
        end
        StFall: begin
          if (on_ground && !y_q[9]) begin
            y_d     = '0;
            state_d = is_walk_key(keycode) ? StWalk : StIdle;
`ifdef PLAYER_DOUBLE_JUMP_EN
            credit_d = 1'b0;
          end else if (jump_edge && credit_q) begin
            y_d      = JumpNeg;
            state_d  = StJump;
            credit_d = 1'b0;
`endif
          end else begin
            y_d = (y_inc > MaxFall11) ? MaxFall11[9:0] : y_inc[9:0];
          end
        end
        StAttack: begin
          x_d = '0;
          y_d = '0;
          if (atk_done) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= StIdle;
      x_q        <= '0;
      y_q        <= '0;
      facing_q   <= 1'b1;
      prev_key_q <= '0;
`ifdef PLAYER_DOUBLE_JUMP_EN
      credit_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      facing_q   <= facing_d;
      prev_key_q <= prev_key_d;
`ifdef PLAYER_DOUBLE_JUMP_EN
      credit_q   <= credit_d;
`endif
    end
  end

  player_attack_timer #(
    .ATTACK_TICKS  (ATTACK_TICKS),
    .COOLDOWN_TICKS(COOLDOWN_TICKS)
  ) u_attack_timer (
    .clk_i          (Clk),
    .rst_ni         (Reset_n),
    .tick_i         (frame_tick),
    .start_i        (atk_start),
    .attack_active_o(atk_active),
    .attack_done_o  (atk_done),
    .ready_o        (atk_ready)
  );

  assign X_Motion      = x_q;
  assign Y_Motion      = y_q;
  assign state         = state_q;
  assign facing_right  = facing_q;
  assign attack_active = atk_active;

endmodule
